// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the CPU fetch
// port (read-only) and the load/store port (read/write). Load/store has
// priority; a starvation counter hands a contested cycle to fetch after
// STARVE_MAX consecutive denials. Read data is routed back through a tag
// pipeline that tracks which port issued each outstanding read.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic [AW-1:0] i_pc_addr,
  input  logic          i_pc_rd,
  output logic          o_pc_waitrequest,
  output logic [DW-1:0] o_pc_rddata,
  output logic          o_pc_rddata_valid,

  input  logic [AW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [DW-1:0] i_ldst_wrdata,
  output logic          o_ldst_waitrequest,
  output logic [DW-1:0] o_ldst_rddata,
  output logic          o_ldst_rddata_valid,

  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic [DW-1:0] i_mem_rddata
);

  localparam int SCW = 4;

  logic [SCW-1:0]    starve_cnt;
  logic              starved;
  logic              pc_req;
  logic              ldst_req;
  logic              ldst_is_rd;
  logic              pc_win;
  logic              ldst_win;
  logic              rd_issue;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_pc;
  logic              ret_vld;
  logic              ret_pc;

  assign pc_req     = i_pc_rd;
  assign ldst_req   = i_ldst_rd | i_ldst_wr;
  // A simultaneous rd+wr from load/store is a plain write.
  assign ldst_is_rd = i_ldst_rd & ~i_ldst_wr;
  assign starved    = (starve_cnt == SCW'(STARVE_MAX));

  // Grant selection; nothing is granted while reset is held low.
  always_comb begin
    pc_win   = 1'b0;
    ldst_win = 1'b0;
    if (reset) begin
      pc_win   = pc_req & (~ldst_req | starved);
      ldst_win = ldst_req & ~pc_win;
    end
  end

  assign o_pc_waitrequest   = ~reset | (pc_req & ~pc_win);
  assign o_ldst_waitrequest = ~reset | (ldst_req & ~ldst_win);
  assign rd_issue           = pc_win | (ldst_win & ldst_is_rd);

  // Memory strobes follow the winner; idle cycles park on the load/store address.
  always_comb begin
    o_mem_addr   = i_ldst_addr;
    o_mem_wrdata = i_ldst_wrdata;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    if (pc_win) begin
      o_mem_addr = i_pc_addr;
      o_mem_rd   = 1'b1;
    end else if (ldst_win) begin
      o_mem_rd   = ldst_is_rd;
      o_mem_wr   = i_ldst_wr;
    end
  end

  // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (pc_req && !pc_win) begin
      if (!starved) starve_cnt <= starve_cnt + SCW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag pipeline: one entry per cycle, aligned with memory read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_pc  <= '0;
    end else begin
      tag_vld[0] <= rd_issue;
      tag_pc[0]  <= pc_win;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_pc[i]  <= tag_pc[i-1];
      end
    end
  end

  assign ret_vld = tag_vld[RD_LAT-1];
  assign ret_pc  = tag_pc[RD_LAT-1];

  // Register returning data into the owner's port; the other port holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_pc_rddata         <= '0;
      o_pc_rddata_valid   <= 1'b0;
      o_ldst_rddata       <= '0;
      o_ldst_rddata_valid <= 1'b0;
    end else begin
      o_pc_rddata_valid   <= ret_vld & ret_pc;
      o_ldst_rddata_valid <= ret_vld & ~ret_pc;
      if (ret_vld && ret_pc)  o_pc_rddata   <= i_mem_rddata;
      if (ret_vld && !ret_pc) o_ldst_rddata <= i_mem_rddata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the same request
// stimulus: u_dut1 with RD_LAT=1 and u_dut2 with RD_LAT=2, each behind its
// own memory model whose read data is f(addr).
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] pc_addr;
  logic        pc_rd;
  logic [15:0] ldst_addr;
  logic        ldst_rd;
  logic        ldst_wr;
  logic [15:0] ldst_wrdata;

  logic        pc_wait1, pc_wait2;
  logic [15:0] pc_data1, pc_data2;
  logic        pc_vld1, pc_vld2;
  logic        ldst_wait1, ldst_wait2;
  logic [15:0] ldst_data1, ldst_data2;
  logic        ldst_vld1, ldst_vld2;
  logic [15:0] mem_addr1, mem_addr2;
  logic        mem_rd1, mem_rd2;
  logic        mem_wr1, mem_wr2;
  logic [15:0] mem_wrdata1, mem_wrdata2;
  logic [15:0] mem_rddata1, mem_rddata2;
  logic [15:0] m2_stage;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .o_pc_waitrequest(pc_wait1),
    .o_pc_rddata(pc_data1), .o_pc_rddata_valid(pc_vld1),
    .i_ldst_addr(ldst_addr), .i_ldst_rd(ldst_rd), .i_ldst_wr(ldst_wr),
    .i_ldst_wrdata(ldst_wrdata), .o_ldst_waitrequest(ldst_wait1),
    .o_ldst_rddata(ldst_data1), .o_ldst_rddata_valid(ldst_vld1),
    .o_mem_addr(mem_addr1), .o_mem_rd(mem_rd1), .o_mem_wr(mem_wr1),
    .o_mem_wrdata(mem_wrdata1), .i_mem_rddata(mem_rddata1)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(2), .STARVE_MAX(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .o_pc_waitrequest(pc_wait2),
    .o_pc_rddata(pc_data2), .o_pc_rddata_valid(pc_vld2),
    .i_ldst_addr(ldst_addr), .i_ldst_rd(ldst_rd), .i_ldst_wr(ldst_wr),
    .i_ldst_wrdata(ldst_wrdata), .o_ldst_waitrequest(ldst_wait2),
    .o_ldst_rddata(ldst_data2), .o_ldst_rddata_valid(ldst_vld2),
    .o_mem_addr(mem_addr2), .o_mem_rd(mem_rd2), .o_mem_wr(mem_wr2),
    .o_mem_wrdata(mem_wrdata2), .i_mem_rddata(mem_rddata2)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : a;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data appears RD_LAT cycles after the address cycle.
  always @(posedge clk) begin
    mem_rddata1 <= mem_f(mem_addr1);
    m2_stage    <= mem_f(mem_addr2);
    mem_rddata2 <= m2_stage;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      pc_rd   = 1'b0;
      ldst_rd = 1'b0;
      ldst_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_rd = 1'b1;
    pc_addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_rd1 !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd1); end
      checks++; if (pc_wait1 !== 1'b1) begin errors++; $display("FAIL reset_pc_wait: got %b expected 1", pc_wait1); end
      checks++; if ({pc_vld1, ldst_vld1} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b expected 00", {pc_vld1, ldst_vld1}); end
      checks++; if ({pc_data1, ldst_data1} !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h expected 0", {pc_data1, ldst_data1}); end
    end
    next_cycle();
    reset = 1'b1;
    pc_rd = 1'b0;
    @(negedge clk);
    checks++; if (pc_wait1 !== 1'b0) begin errors++; $display("FAIL idle_pc_wait: got %b expected 0", pc_wait1); end
    idle(2);
  endtask

  task automatic test_fetch_only();
    next_cycle();
    pc_rd = 1'b1;
    pc_addr = 16'h0010;
    @(negedge clk);
    checks++; if (mem_rd1 !== 1'b1) begin errors++; $display("FAIL fetch_mem_rd: got %b expected 1", mem_rd1); end
    checks++; if (mem_addr1 !== 16'h0010) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 0010", mem_addr1); end
    checks++; if (pc_wait1 !== 1'b0) begin errors++; $display("FAIL fetch_pc_wait: got %b expected 0", pc_wait1); end
    next_cycle();
    pc_rd = 1'b0;
    @(negedge clk);
    checks++; if (pc_vld1 !== 1'b0) begin errors++; $display("FAIL fetch_early_valid: got %b expected 0", pc_vld1); end
    next_cycle();
    @(negedge clk);
    checks++; if (pc_vld1 !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b expected 1", pc_vld1); end
    checks++; if (pc_data1 !== 16'h1234) begin errors++; $display("FAIL fetch_data: got %h expected 1234", pc_data1); end
    checks++; if (ldst_vld1 !== 1'b0) begin errors++; $display("FAIL fetch_ldst_valid: got %b expected 0", ldst_vld1); end
    next_cycle();
    @(negedge clk);
    checks++; if (pc_vld1 !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b expected 0", pc_vld1); end
    idle(4);
  endtask

  task automatic test_contention();
    int  waits;
    logic exp_pc, exp_pv, exp_lv;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      pc_rd = 1'b1;
      pc_addr = 16'h0040;
      ldst_rd = 1'b1;
      ldst_addr = 16'h0050;
      @(negedge clk);
      exp_pc = ((i % 5) == 4);
      exp_lv = (i >= 2) && (((i - 2) % 5) != 4);
      exp_pv = (i >= 2) && (((i - 2) % 5) == 4);
      if (pc_wait1) waits++;
      checks++; if (pc_wait1 !== !exp_pc) begin errors++; $display("FAIL cont_pc_wait[%0d]: got %b expected %b", i, pc_wait1, !exp_pc); end
      checks++; if (ldst_wait1 !== exp_pc) begin errors++; $display("FAIL cont_ldst_wait[%0d]: got %b expected %b", i, ldst_wait1, exp_pc); end
      checks++; if (mem_addr1 !== (exp_pc ? 16'h0040 : 16'h0050)) begin errors++; $display("FAIL cont_mem_addr[%0d]: got %h expected %h", i, mem_addr1, exp_pc ? 16'h0040 : 16'h0050); end
      checks++; if (ldst_vld1 !== exp_lv) begin errors++; $display("FAIL cont_ldst_valid[%0d]: got %b expected %b", i, ldst_vld1, exp_lv); end
      checks++; if (pc_vld1 !== exp_pv) begin errors++; $display("FAIL cont_pc_valid[%0d]: got %b expected %b", i, pc_vld1, exp_pv); end
    end
    checks++; if (waits !== 8) begin errors++; $display("FAIL cont_wait_count: got %0d expected 8", waits); end
    checks++; if (ldst_data1 !== 16'h0050) begin errors++; $display("FAIL cont_ldst_data: got %h expected 0050", ldst_data1); end
    checks++; if (pc_data1 !== 16'h0040) begin errors++; $display("FAIL cont_pc_data: got %h expected 0040", pc_data1); end
    idle(4);
  endtask

  task automatic test_store_vs_fetch();
    next_cycle();
    ldst_wr = 1'b1;
    ldst_addr = 16'h0020;
    ldst_wrdata = 16'hBEEF;
    pc_rd = 1'b1;
    pc_addr = 16'h0030;
    @(negedge clk);
    checks++; if ({mem_wr1, mem_rd1} !== 2'b10) begin errors++; $display("FAIL store_strobes: got %b expected 10", {mem_wr1, mem_rd1}); end
    checks++; if ({mem_addr1, mem_wrdata1} !== {16'h0020, 16'hBEEF}) begin errors++; $display("FAIL store_addr_data: got %h expected 0020beef", {mem_addr1, mem_wrdata1}); end
    checks++; if ({pc_wait1, ldst_wait1} !== 2'b10) begin errors++; $display("FAIL store_waits: got %b expected 10", {pc_wait1, ldst_wait1}); end
    next_cycle();
    ldst_wr = 1'b0;
    @(negedge clk);
    checks++; if ({pc_wait1, mem_rd1, mem_wr1} !== 3'b010) begin errors++; $display("FAIL store_pc_grant: got %b expected 010", {pc_wait1, mem_rd1, mem_wr1}); end
    checks++; if (mem_addr1 !== 16'h0030) begin errors++; $display("FAIL store_pc_addr: got %h expected 0030", mem_addr1); end
    next_cycle();
    pc_rd = 1'b0;
    @(negedge clk);
    checks++; if ({pc_vld1, ldst_vld1} !== 2'b00) begin errors++; $display("FAIL store_no_early_valid: got %b expected 00", {pc_vld1, ldst_vld1}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({pc_vld1, ldst_vld1} !== 2'b10) begin errors++; $display("FAIL store_pc_valid: got %b expected 10", {pc_vld1, ldst_vld1}); end
    checks++; if (pc_data1 !== 16'h0030) begin errors++; $display("FAIL store_pc_data: got %h expected 0030", pc_data1); end
    idle(4);
  endtask

  task automatic test_interleaved_lat2();
    logic exp_lv, exp_pv;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      pc_rd   = (i < 6) && ((i % 2) == 1);
      ldst_rd = (i < 6) && ((i % 2) == 0);
      pc_addr = 16'h0200;
      ldst_addr = 16'h0100;
      @(negedge clk);
      exp_lv = (i >= 3) && (i < 9) && (((i - 3) % 2) == 0);
      exp_pv = (i >= 3) && (i < 9) && (((i - 3) % 2) == 1);
      checks++; if (ldst_vld2 !== exp_lv) begin errors++; $display("FAIL lat2_ldst_valid[%0d]: got %b expected %b", i, ldst_vld2, exp_lv); end
      checks++; if (pc_vld2 !== exp_pv) begin errors++; $display("FAIL lat2_pc_valid[%0d]: got %b expected %b", i, pc_vld2, exp_pv); end
      if (exp_lv) begin
        checks++; if (ldst_data2 !== 16'h0100) begin errors++; $display("FAIL lat2_ldst_data[%0d]: got %h expected 0100", i, ldst_data2); end
      end
      if (exp_pv) begin
        checks++; if (pc_data2 !== 16'h0200) begin errors++; $display("FAIL lat2_pc_data[%0d]: got %h expected 0200", i, pc_data2); end
      end
    end
    idle(2);
  endtask

  task automatic test_rd_wr_both();
    next_cycle();
    ldst_rd = 1'b1;
    ldst_wr = 1'b1;
    ldst_addr = 16'h0060;
    ldst_wrdata = 16'h5A5A;
    @(negedge clk);
    checks++; if ({mem_wr1, mem_rd1, ldst_wait1} !== 3'b100) begin errors++; $display("FAIL rdwr_strobes: got %b expected 100", {mem_wr1, mem_rd1, ldst_wait1}); end
    checks++; if (mem_wrdata1 !== 16'h5A5A) begin errors++; $display("FAIL rdwr_wrdata: got %h expected 5a5a", mem_wrdata1); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ldst_rd = 1'b0;
      ldst_wr = 1'b0;
      @(negedge clk);
      checks++; if ({ldst_vld1, ldst_vld2} !== 2'b00) begin errors++; $display("FAIL rdwr_no_response[%0d]: got %b expected 00", i, {ldst_vld1, ldst_vld2}); end
    end
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    pc_rd = 1'b1;
    pc_addr = 16'h0010;
    @(negedge clk);
    checks++; if (mem_rd1 !== 1'b1) begin errors++; $display("FAIL mid_issue: got %b expected 1", mem_rd1); end
    next_cycle();
    pc_rd = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({pc_wait1, ldst_wait1} !== 2'b11) begin errors++; $display("FAIL mid_reset_waits: got %b expected 11", {pc_wait1, ldst_wait1}); end
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({pc_vld1, pc_vld2} !== 2'b00) begin errors++; $display("FAIL mid_no_valid[%0d]: got %b expected 00", i, {pc_vld1, pc_vld2}); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (pc_data1 !== 16'h0000) begin errors++; $display("FAIL mid_rddata_cleared: got %h expected 0000", pc_data1); end
  endtask

  initial begin
    reset = 1'b0;
    pc_addr = '0;
    pc_rd = 1'b0;
    ldst_addr = '0;
    ldst_rd = 1'b0;
    ldst_wr = 1'b0;
    ldst_wrdata = '0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_vs_fetch();
    test_interleaved_lat2();
    test_rd_wr_both();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the CPU instruction-fetch port (read-only) and load/store port (read/write). It sits between the cpu core and the memory. It grants at most one memory access per cycle, stalls the losing requester with waitrequest, and routes pipelined read data back to the requester that issued the read. Load/store has priority, and a starvation counter guarantees fetch progress.

Parameters:
AW, 16, address width in bits
DW, 16, data width in bits
RD_LAT, 1, memory read latency in cycles from o_mem_rd to valid i_mem_rddata (legal 1..4)
STARVE_MAX, 4, consecutive denied fetch cycles before fetch wins a contested cycle (legal 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_pc_addr  in  AW  fetch address
i_pc_rd  in  1  fetch read request
o_pc_waitrequest  out  1  fetch request not accepted this cycle
o_pc_rddata  out  DW  fetch read data
o_pc_rddata_valid  out  1  o_pc_rddata valid, one-cycle pulse per accepted read
i_ldst_addr  in  AW  load/store address
i_ldst_rd  in  1  load request
i_ldst_wr  in  1  store request
i_ldst_wrdata  in  DW  store data
o_ldst_waitrequest  out  1  load/store request not accepted this cycle
o_ldst_rddata  out  DW  load read data
o_ldst_rddata_valid  out  1  o_ldst_rddata valid pulse
o_mem_addr  out  AW  memory address
o_mem_rd  out  1  memory read strobe
o_mem_wr  out  1  memory write strobe
o_mem_wrdata  out  DW  memory write data
i_mem_rddata  in  DW  memory read data, valid RD_LAT cycles after o_mem_rd

Behaviour:
- Reset (reset=0, async): starve_cnt=0, tag pipeline cleared, o_*_rddata=0, o_*_rddata_valid=0. o_mem_rd=o_mem_wr=0 and both waitrequests=1 while reset is low.
- Request protocol: a requester holds addr/rd/wr/wrdata stable while its waitrequest=1. A request is accepted in the cycle its waitrequest=0. waitrequest is combinational: it equals request AND NOT grant. With no request, waitrequest=0.
- ldst request = i_ldst_rd | i_ldst_wr. If both are set, treat it as a write only: o_mem_rd=0 and no read tag.
- Grant, combinational per cycle:
  - only one side requests: that side wins.
  - both request: ldst wins unless starve_cnt==STARVE_MAX, in which case pc wins.
- starve_cnt, registered: +1 when pc requests and is denied; reset to 0 when pc is granted or pc is not requesting. Saturates at STARVE_MAX.
- Memory drive, combinational from the winner: o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata. With no grant, o_mem_rd=o_mem_wr=0, o_mem_addr holds the ldst address, and o_mem_wrdata holds i_ldst_wrdata.
- Writes complete in the grant cycle and produce no response.
- Read return:
  - Tag shift register, RD_LAT deep, entry {valid, owner}. Each granted read pushes {1, owner}; other cycles push {0, x}.
  - When the tag at depth RD_LAT is valid, i_mem_rddata is registered into the owner's o_*_rddata and that owner's valid pulses for one cycle.
  - Total read latency: accept cycle to valid = RD_LAT+1 cycles.
  - Responses return in issue order. The non-owner's rddata holds its previous value.
- Throughput: one access per cycle with back-to-back reads fully pipelined. No bubbles are inserted between owners.
- Reset mid-flight: in-flight tags are discarded and no valid pulses after reset release for reads issued before reset.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with i_pc_rd=1 -> o_mem_rd=0, o_pc_waitrequest=1, both valids 0, both rddata 0x0000.
2. Fetch-only read, RD_LAT=1: i_pc_rd=1, addr 0x0010 in cycle T; memory returns 0x1234 at T+1 -> o_mem_rd=1 and o_mem_addr=0x0010 at T, o_pc_waitrequest=0 at T, o_pc_rddata_valid=1 with 0x1234 at T+2 only, o_ldst_rddata_valid=0.
3. Contention, STARVE_MAX=4: both ports read continuously -> grants follow ldst×4, pc×1, repeating; o_pc_waitrequest is high exactly 4 of every 5 cycles; starve_cnt never exceeds 4.
4. Store vs fetch: ldst write 0x0020/0xBEEF and pc read 0x0030 in the same cycle T -> o_mem_wr=1 with 0x0020/0xBEEF at T, pc granted at T+1, no ldst valid pulse; o_pc_rddata_valid at T+1+RD_LAT+1.
5. Interleaved reads, RD_LAT=2: alternating ldst/pc reads to 0x0100/0x0200 with memory data = address -> each valid pulse goes to the issuing port, data matches address, order is preserved, and there are no dropped or extra pulses.
6. Edge cases:
   - i_ldst_rd=i_ldst_wr=1 -> single write, no read response.
   - reset pulsed low one cycle after a read issue -> no valid pulse ever appears for that read.
